// File: rtl/ddr_resp_pkg.sv
// ddr_resp_pkg: shared widths, FSM state and request record for the DDR responder
package ddr_resp_pkg;
  localparam int BEAT_WIDTH = 64;
  localparam int LINE_WIDTH = 512;
  localparam int BURST_BEATS = 8;
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  typedef struct packed {
    logic [63:0] index;
    logic we;
    logic burst;
    logic [LINE_WIDTH-1:0] mask;
    logic [LINE_WIDTH-1:0] data;
  } req_t;
endpackage

// File: rtl/ddr_word_ram.sv
// ddr_word_ram: 2^DEPTH_LOG x 64-bit array; bit-masked write, combinational read (clock, we/addr/mask/wdata/rdata access port, pre_we/pre_addr/pre_data preload port; an access-port write beats a preload to the same word)
module ddr_word_ram
  import ddr_resp_pkg::*;
#(
  parameter int DEPTH_LOG = 16
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG-1:0]  addr,
  input  logic [BEAT_WIDTH-1:0] mask,
  input  logic [BEAT_WIDTH-1:0] wdata,
  output logic [BEAT_WIDTH-1:0] rdata,
  input  logic                  pre_we,
  input  logic [DEPTH_LOG-1:0]  pre_addr,
  input  logic [BEAT_WIDTH-1:0] pre_data
);
  logic [BEAT_WIDTH-1:0] mem [0:(1<<DEPTH_LOG)-1];
  always_ff @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (we) mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/ddr_responder.sv
// ddr_responder: memory-side DDR channel end with latency model, single/8-beat bursts and preload (clock/reset, ddr_* request/response channel, pre_* preload port)
module ddr_responder #(
  parameter int DEPTH_LOG = 16,
  parameter int LATENCY = 4,
  parameter int BURST_BEATS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ddr_chip_enable,
  input  logic [63:0]          ddr_index,
  input  logic                 ddr_write_enable,
  input  logic                 ddr_burst_mode,
  input  logic [511:0]         ddr_write_mask,
  input  logic [511:0]         ddr_write_data,
  output logic [511:0]         ddr_read_data,
  output logic                 ddr_operation_done,
  output logic                 ddr_ready,
  input  logic                 pre_we,
  input  logic [DEPTH_LOG-1:0] pre_addr,
  input  logic [63:0]          pre_data
);
  import ddr_resp_pkg::*;
  localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t state, next_state;
  req_t req;
  logic [2:0] beat;
  logic [LW-1:0] lat_cnt;
  logic accept, last, ram_we, unused_idx;
  logic [DEPTH_LOG-1:0] base, addr;
  logic [BEAT_WIDTH-1:0] ram_rdata;
  assign accept = state == IDLE && ddr_chip_enable && ddr_ready;
  assign last = beat == (req.burst ? 3'(BURST_BEATS - 1) : 3'd0);
  // bursts are line-aligned; base + beat wraps inside the array
  assign base = req.burst ? {req.index[DEPTH_LOG-1:3], 3'b000} : req.index[DEPTH_LOG-1:0];
  assign addr = base + DEPTH_LOG'(beat);
  assign unused_idx = ^req.index[63:DEPTH_LOG];
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state == IDLE ? (accept ? (LATENCY == 0 ? XFER : WAIT) : IDLE)
               : state == WAIT ? (lat_cnt == '0 ? XFER : WAIT)
               : state == XFER ? (last ? DONE : XFER)
               : IDLE;
  end
  // gating with reset stops the beat in flight when an operation is aborted
  always_comb begin
    ddr_operation_done = state == DONE;
    ram_we = state == XFER && req.we && !reset;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ddr_ready <= 1'b0;
      ddr_read_data <= '0;
      beat <= '0;
      lat_cnt <= '0;
    end else begin
      ddr_ready <= next_state == IDLE;
      if (accept) begin
        req <= '{index: ddr_index, we: ddr_write_enable, burst: ddr_burst_mode,
                 mask: ddr_write_mask, data: ddr_write_data};
        ddr_read_data <= '0;
        beat <= '0;
        lat_cnt <= LW'(LATENCY - 1);
      end
      if (state == WAIT) lat_cnt <= lat_cnt - 1'b1;
      if (state == XFER) begin
        beat <= beat + 1'b1;
        if (!req.we) ddr_read_data[beat*BEAT_WIDTH +: BEAT_WIDTH] <= ram_rdata;
      end
    end
  end
  ddr_word_ram #(.DEPTH_LOG(DEPTH_LOG)) u_ram (
    .clock   (clock),
    .we      (ram_we),
    .addr    (addr),
    .mask    (req.mask[beat*BEAT_WIDTH +: BEAT_WIDTH]),
    .wdata   (req.data[beat*BEAT_WIDTH +: BEAT_WIDTH]),
    .rdata   (ram_rdata),
    .pre_we  (pre_we),
    .pre_addr(pre_addr),
    .pre_data(pre_data)
  );
endmodule

// File: tb/tb_ddr_responder.sv
// tb_ddr_responder: directed self-checking bench for ddr_responder
module tb_ddr_responder;
  logic clock = 0, reset = 1;
  logic ddr_chip_enable = 0, ddr_write_enable = 0, ddr_burst_mode = 0;
  logic [63:0] ddr_index = '0;
  logic [511:0] ddr_write_mask = '0, ddr_write_data = '0, ddr_read_data;
  logic ddr_operation_done, ddr_ready;
  logic pre_we = 0;
  logic [15:0] pre_addr = '0;
  logic [63:0] pre_data = '0;
  int n_cmp = 0, n_bad = 0, cyc = 0, t_acc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  ddr_responder dut (
    .clock(clock), .reset(reset), .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
    .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done),
    .ddr_ready(ddr_ready), .pre_we(pre_we), .pre_addr(pre_addr), .pre_data(pre_data)
  );
  task automatic check(input string tag, input logic [511:0] got, exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic preload(input logic [15:0] a, input logic [63:0] d);
    pre_we = 1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 0;
  endtask
  task automatic issue(input logic [63:0] idx, input logic we, burst, input logic [511:0] m, d);
    int n = 0;
    while (!ddr_ready && n < 50) begin @(negedge clock); n++; end
    if (!ddr_ready) check("issue_ready", 0, 1);
    ddr_chip_enable = 1; ddr_index = idx; ddr_write_enable = we; ddr_burst_mode = burst;
    ddr_write_mask = m; ddr_write_data = d; t_acc = cyc;
    @(negedge clock);
    ddr_chip_enable = 0;
  endtask
  task automatic wait_done(output int nd, output int td, output logic [511:0] rd);
    nd = 0; td = -1; rd = '0;
    for (int i = 0; i < 20; i++) begin
      if (ddr_operation_done) begin
        nd++;
        if (nd == 1) begin td = cyc - t_acc; rd = ddr_read_data; end
      end
      @(negedge clock);
    end
  endtask
  task automatic op(input string tag, input logic [63:0] idx, input logic we, burst,
                    input logic [511:0] m, d, ex, input int lat);
    int nd, td;
    logic [511:0] rd;
    issue(idx, we, burst, m, d);
    check({tag, "_busy"}, ddr_ready, 0);
    wait_done(nd, td, rd);
    check({tag, "_ndone"}, nd, 1);
    check({tag, "_tdone"}, td, lat);
    check({tag, "_data"}, rd, ex);
  endtask
  initial begin
    logic [511:0] ex, ones;
    int nd, t1, t2;
    ones = '1;
    @(negedge clock);
    preload(16'h0010, 64'hDEADBEEF_CAFEF00D);
    for (int k = 0; k < 8; k++) preload(16'h0040 + 16'(k), 64'h40 + 64'(k));
    preload(16'h0020, 64'h0);
    for (int k = 0; k < 8; k++) preload(16'hFFF8 + 16'(k), 64'hA000 + 64'(k));
    for (int k = 0; k < 8; k++) preload(16'h0080 + 16'(k), 64'h5555_0000_0000_0000 | 64'(k));
    check("rst_ready", ddr_ready, 0);
    check("rst_done", ddr_operation_done, 0);
    check("rst_rdata", ddr_read_data, 0);
    reset = 0;
    @(negedge clock);
    check("ready_after_rst", ddr_ready, 1);
    op("single_rd", 64'h10, 0, 0, '0, '0, {448'h0, 64'hDEADBEEF_CAFEF00D}, 6);
    for (int k = 0; k < 8; k++) ex[64*k +: 64] = 64'h40 + 64'(k);
    op("burst_rd", 64'h43, 0, 1, '0, '0, ex, 13);
    op("single_wr", 64'h20, 1, 0, {448'h0, 64'h0000_0000_FFFF_0000}, ones, '0, 6);
    op("single_rb", 64'h20, 0, 0, '0, '0, {448'h0, 64'h0000_0000_FFFF_0000}, 6);
    op("burst_wr_m0", 64'h20, 1, 1, '0, ones, '0, 13);
    op("m0_rb", 64'h20, 0, 0, '0, '0, {448'h0, 64'h0000_0000_FFFF_0000}, 6);
    issue(64'h10, 0, 0, '0, '0);
    nd = 0; t1 = -1; t2 = -1;
    for (int i = 1; i <= 20; i++) begin
      ddr_chip_enable = (i == 2 || i == 7);
      if (ddr_operation_done) begin
        nd++;
        if (nd == 1) t1 = cyc - t_acc; else t2 = cyc - t_acc;
      end
      @(negedge clock);
    end
    ddr_chip_enable = 0;
    check("busy_ndone", nd, 2);
    check("busy_t1", t1, 6);
    check("busy_t2", t2, 13);
    op("wrap_rd", 64'h1_0000_0010, 0, 0, '0, '0, {448'h0, 64'hDEADBEEF_CAFEF00D}, 6);
    for (int k = 0; k < 8; k++) ex[64*k +: 64] = 64'hA000 + 64'(k);
    op("top_burst", 64'hFFFB, 0, 1, '0, '0, ex, 13);
    for (int k = 0; k < 8; k++) ex[64*k +: 64] = 64'hC0DE_0000_0000_0000 | 64'(k);
    issue(64'h80, 1, 1, ones, ex);
    nd = 0;
    for (int i = 1; i < 8; i++) begin
      if (ddr_operation_done) nd++;
      @(negedge clock);
    end
    reset = 1;
    @(negedge clock);
    if (ddr_operation_done) nd++;
    check("abort_ready", ddr_ready, 0);
    check("abort_done", ddr_operation_done, 0);
    check("abort_rdata", ddr_read_data, 0);
    reset = 0;
    @(negedge clock);
    if (ddr_operation_done) nd++;
    check("abort_ready_back", ddr_ready, 1);
    check("abort_ndone", nd, 0);
    for (int k = 0; k < 8; k++)
      ex[64*k +: 64] = k < 3 ? (64'hC0DE_0000_0000_0000 | 64'(k)) : (64'h5555_0000_0000_0000 | 64'(k));
    op("abort_rb", 64'h80, 0, 1, '0, '0, ex, 13);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr_responder.md
Name: ddr_responder

Overview:
- Memory-side end of the DDR channel driven by the core's channel arbiter: accepts single-word and 8-beat burst read/write requests, models access latency, and returns read data with a one-cycle done pulse.
- Sits outside core_top in the simulation top and SoC test harness, backed by an internal 64-bit-word array.
- Also provides a preload port so the bench can load program images before releasing the core.

Parameters:
- DEPTH_LOG, 16, log2 of array depth in 64-bit words.
- LATENCY, 4, WAIT cycles between accept and first beat; 0 is legal and skips WAIT.
- BURST_BEATS, 8, beats per burst; fixed at 8, so a burst carries 512 bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ddr_chip_enable  in  1  request strobe, qualified by ddr_ready.
- ddr_index  in  64  64-bit-word index; only [DEPTH_LOG-1:0] used.
- ddr_write_enable  in  1  1 = write, 0 = read.
- ddr_burst_mode  in  1  1 = 8-beat line access, 0 = single word.
- ddr_write_mask  in  512  per-bit write enable; beat k uses [64k+63:64k].
- ddr_write_data  in  512  write data; beat k uses [64k+63:64k].
- ddr_read_data  out  512  read result, valid while ddr_operation_done = 1 and held afterwards.
- ddr_operation_done  out  1  one-cycle completion pulse.
- ddr_ready  out  1  responder can accept a request this cycle.
- pre_we  in  1  preload write strobe.
- pre_addr  in  DEPTH_LOG  preload word index.
- pre_data  in  64  preload data; full-word write.

Behaviour:
- Reset values: ddr_ready = 0, ddr_operation_done = 0, ddr_read_data = 0, state = IDLE, beat counter = 0, latency counter = 0.
- Array contents are not reset.
- ddr_ready is registered and rises in the first cycle after reset deasserts.
- States: IDLE, WAIT, XFER, DONE.
- IDLE: ddr_ready = 1. Accept when ddr_chip_enable && ddr_ready at edge T.
  - Latch index, write_enable, burst_mode, mask and data.
  - Clear read-data register.
  - Go to WAIT, or to XFER if LATENCY = 0.
  - ddr_ready = 0 from T+1.
- WAIT: down-counter loaded with LATENCY-1; go to XFER when it reaches 0.
- XFER: one beat per cycle, N = 8 for burst, N = 1 for single.
  - Burst base = index with [2:0] forced to 0; beat k addresses base + k.
  - Single access uses the index as-is and beat slot 0.
  - Read: beat k's word goes into read-data [64k+63:64k]; unused slots stay 0.
  - Write: array word = (old & ~mask_k) | (data_k & mask_k); mask all-zero means no change.
  - After the last beat, go to DONE.
- DONE: ddr_operation_done = 1 for exactly one cycle, then IDLE.
  - ddr_read_data is stable from DONE until the next accept.
  - For writes, ddr_read_data is 0.
- Timing: done is high in cycle T + LATENCY + N + 1.
  - Example, LATENCY = 4: single at T+6, burst at T+13.
  - ddr_ready is back high in the cycle after DONE.
- Busy: ddr_chip_enable while ddr_ready = 0 is ignored, with no queueing. The initiator must hold or re-present the request.
- Address wrap: index bits above DEPTH_LOG are ignored, and base + k wraps modulo 2^DEPTH_LOG.
- Preload: accepted in any state.
  - If the same word is written by XFER in the same cycle, XFER wins.
  - A read beat in the same cycle as a preload to the same word returns the old value.
- Reset mid-operation: the request is aborted immediately.
  - Beats already written remain; no further writes occur.
  - No done pulse is generated.
- Request inputs are don't-care outside the accept cycle.

Decomposition:
- Package ddr_resp_pkg holds:
  - BEAT_WIDTH = 64, LINE_WIDTH = 512, BURST_BEATS = 8;
  - state enum {IDLE, WAIT, XFER, DONE};
  - a request struct {index, we, burst, mask, data}.
- Sub-module ddr_word_ram: single-port, 64-bit-wide array of 2^DEPTH_LOG words.
  - Bit-mask write, combinational read.
  - Separate preload write port, with the priority rule above.
- ddr_responder holds the FSM, counters, request latch and read-data assembly.

Test Plan:
- Preload word 0x10 = 0xDEADBEEF_CAFEF00D; single read of index 0x10 accepted at cycle T → ready low at T+1, done at T+6, read_data[63:0] = 0xDEADBEEF_CAFEF00D, [511:64] = 0.
- Preload words 0x40..0x47 with value = index; burst read of index 0x43 → done at T+13, read_data beat k = 0x40+k for k = 0..7.
- Single write index 0x20, data[63:0] = 0xFFFF_FFFF_FFFF_FFFF, mask[63:0] = 0x0000_0000_FFFF_0000 over preloaded 0 → read back 0x0000_0000_FFFF_0000. Then burst write to 0x20 with mask = 0 → word unchanged.
- Second ddr_chip_enable at T+2 during a busy read → ignored, exactly one done pulse; same request re-presented at T+7 → accepted, done at T+13.
- Read of index 0x1_0000_0010 with DEPTH_LOG = 16 → returns word 0x10; burst at index 0xFFFB → beats cover 0xFFF8..0xFFFF.
- Burst write issued, reset asserted in XFER after 3 beats → no done pulse; outputs = reset values; ready high the cycle after reset drops; words base..base+2 updated, base+3..base+7 unchanged.
